cache_assoc_wb: RTL and testbench

Parametrised fully associative write-back, write-allocate cache with true-LRU replacement. It sits between the circuit-side requester and the `ramlpm` block memory, and is the next generation of the 4-line, 7-bit-tag cache. It generalises line count and widths, and replaces the implicit memory access with an explicit request/acknowledge handshake to memory. Writes are fully supported, with dirty-line write-back on eviction.

---
 rtl/cache_assoc_wb.sv | 247 ++++++++++++++++++++++++
 tb/tb_cache_assoc_wb.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_assoc_wb.sv
// Fully associative write-back / write-allocate cache with true-LRU replacement.
// Latency: hit completes 1 cycle after acceptance; miss = write-back (if dirty) + fill + 1 RESP cycle.
// Backpressure: Req ignored while Busy=1; memory transfers hold until M_Ack_C is sampled high.
//
// Optional feature macro: CACHE_FLUSH_EN (adds Flush input and a flush/write-back-all state).
// Ports:
//   Clock, Resetn                 - rising-edge clock, async active-low reset
//   Req, Write, Address, BlockIn  - requester side, sampled only while Busy=0
//   BlockOut, Done, hit, Busy     - completion data/pulse/outcome, busy flag
//   C_Req_M, C_Write_M, C_Addr_M, C_Block_M - registered memory request
//   M_Block_C, M_Ack_C            - memory fill data and acknowledge
//   Flush (CACHE_FLUSH_EN only)   - write back all dirty lines then invalidate
module cache_assoc_wb #(
  parameter int NUM_LINES = 4,
  parameter int ADDR_W    = 7,
  parameter int DATA_W    = 5
) (
  input  logic              Clock,
  input  logic              Resetn,
  input  logic              Req,
  input  logic              Write,
  input  logic [ADDR_W-1:0] Address,
  input  logic [DATA_W-1:0] BlockIn,
`ifdef CACHE_FLUSH_EN
  input  logic              Flush,
`endif
  output logic [DATA_W-1:0] BlockOut,
  output logic              Done,
  output logic              hit,
  output logic              Busy,
  output logic              C_Req_M,
  output logic              C_Write_M,
  output logic [ADDR_W-1:0] C_Addr_M,
  output logic [DATA_W-1:0] C_Block_M,
  input  logic [DATA_W-1:0] M_Block_C,
  input  logic              M_Ack_C
);

  localparam int IW = (NUM_LINES > 1) ? $clog2(NUM_LINES) : 1;
  localparam logic [IW-1:0] AGE_MAX = IW'(NUM_LINES - 1);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_WB    = 3'd1;
  localparam logic [2:0] ST_FILL  = 3'd2;
  localparam logic [2:0] ST_RESP  = 3'd3;
`ifdef CACHE_FLUSH_EN
  localparam logic [2:0] ST_FLUSH = 3'd4;
`endif

  logic [2:0]           state;
  logic [NUM_LINES-1:0] valid;
  logic [NUM_LINES-1:0] dirty;
  logic [ADDR_W-1:0]    tag  [NUM_LINES];
  logic [DATA_W-1:0]    data [NUM_LINES];
  logic [IW-1:0]        age  [NUM_LINES];

  logic                 lat_write;
  logic [ADDR_W-1:0]    lat_addr;
  logic [DATA_W-1:0]    lat_din;
  logic [IW-1:0]        victim;     // also the scan pointer during a flush
`ifdef CACHE_FLUSH_EN
  logic                 flushing;   // WB returns to FLUSH instead of FILL
`endif

  logic          take;
  logic          hit_c;
  logic [IW-1:0] hit_idx;
  logic [IW-1:0] vic_c;
  logic          any_inv;
  logic          lru_upd;
  logic [IW-1:0] lru_idx;

`ifdef CACHE_FLUSH_EN
  assign take = Req && !Flush;
`else
  assign take = Req;
`endif

  assign Busy = (state != ST_IDLE);

  // Parallel tag compare and victim choice. Descending scan so the lowest
  // invalid index wins; with no invalid line, the oldest (age max) is taken.
  always_comb begin
    hit_c   = 1'b0;
    hit_idx = '0;
    vic_c   = '0;
    any_inv = 1'b0;
    for (int i = NUM_LINES - 1; i >= 0; i--) begin
      if (valid[i] && tag[i] == Address) begin
        hit_c   = 1'b1;
        hit_idx = IW'(i);
      end
      if (!valid[i]) begin
        any_inv = 1'b1;
        vic_c   = IW'(i);
      end
    end
    if (!any_inv) begin
      for (int i = 0; i < NUM_LINES; i++) begin
        if (age[i] == AGE_MAX) vic_c = IW'(i);
      end
    end
  end

  assign lru_upd = (state == ST_RESP) || (state == ST_IDLE && take && hit_c);
  assign lru_idx = (state == ST_RESP) ? victim : hit_idx;

  // True LRU: younger-than-accessed lines age by one, accessed line becomes 0,
  // which keeps the ages a permutation.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      for (int i = 0; i < NUM_LINES; i++) age[i] <= IW'(i);
    end else if (lru_upd) begin
      for (int i = 0; i < NUM_LINES; i++) begin
        if (age[i] < age[lru_idx]) age[i] <= age[i] + IW'(1);
      end
      age[lru_idx] <= '0;
    end
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state     <= ST_IDLE;
      valid     <= '0;
      dirty     <= '0;
      for (int i = 0; i < NUM_LINES; i++) begin
        tag[i]  <= '0;
        data[i] <= '0;
      end
      lat_write <= 1'b0;
      lat_addr  <= '0;
      lat_din   <= '0;
      victim    <= '0;
`ifdef CACHE_FLUSH_EN
      flushing  <= 1'b0;
`endif
      BlockOut  <= '0;
      Done      <= 1'b0;
      hit       <= 1'b0;
      C_Req_M   <= 1'b0;
      C_Write_M <= 1'b0;
      C_Addr_M  <= '0;
      C_Block_M <= '0;
    end else begin
      Done <= 1'b0;
      case (state)
        ST_IDLE: begin
`ifdef CACHE_FLUSH_EN
          if (Flush) begin
            flushing <= 1'b1;
            victim   <= '0;
            state    <= ST_FLUSH;
          end else
`endif
          if (Req) begin
            lat_write <= Write;
            lat_addr  <= Address;
            lat_din   <= BlockIn;
            if (hit_c) begin
              Done <= 1'b1;
              hit  <= 1'b1;
              if (Write) begin
                data[hit_idx]  <= BlockIn;
                dirty[hit_idx] <= 1'b1;
                BlockOut       <= BlockIn;
              end else begin
                BlockOut <= data[hit_idx];
              end
            end else begin
              victim  <= vic_c;
              C_Req_M <= 1'b1;
              if (valid[vic_c] && dirty[vic_c]) begin
                C_Write_M <= 1'b1;
                C_Addr_M  <= tag[vic_c];
                C_Block_M <= data[vic_c];
                state     <= ST_WB;
              end else begin
                C_Write_M <= 1'b0;
                C_Addr_M  <= Address;
                state     <= ST_FILL;
              end
            end
          end
        end
        ST_WB: begin
          if (M_Ack_C) begin
            dirty[victim] <= 1'b0;
            C_Write_M     <= 1'b0;
`ifdef CACHE_FLUSH_EN
            if (flushing) begin
              C_Req_M <= 1'b0;
              state   <= ST_FLUSH;
            end else
`endif
            begin
              C_Addr_M <= lat_addr;
              state    <= ST_FILL;
            end
          end
        end
        ST_FILL: begin
          if (M_Ack_C) begin
            data[victim]  <= M_Block_C;
            tag[victim]   <= lat_addr;
            valid[victim] <= 1'b1;
            C_Req_M       <= 1'b0;
            state         <= ST_RESP;
          end
        end
        ST_RESP: begin
          Done <= 1'b1;
          hit  <= 1'b0;
          if (lat_write) begin
            data[victim]  <= lat_din;
            dirty[victim] <= 1'b1;
            BlockOut      <= lat_din;
          end else begin
            BlockOut <= data[victim];
          end
          state <= ST_IDLE;
        end
`ifdef CACHE_FLUSH_EN
        // A written-back line is re-examined once clean, then the scan moves on.
        ST_FLUSH: begin
          if (dirty[victim]) begin
            C_Req_M   <= 1'b1;
            C_Write_M <= 1'b1;
            C_Addr_M  <= tag[victim];
            C_Block_M <= data[victim];
            state     <= ST_WB;
          end else if (victim == AGE_MAX) begin
            valid    <= '0;
            flushing <= 1'b0;
            Done     <= 1'b1;
            hit      <= 1'b0;
            state    <= ST_IDLE;
          end else begin
            victim <= victim + IW'(1);
          end
        end
`endif
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_assoc_wb.sv
// Directed bench for cache_assoc_wb: table of accesses with hand-computed
// results, plus hand sequences for busy/ignore, back-to-back hits, reset
// mid-fill and (with CACHE_FLUSH_EN) flush.
module tb_cache_assoc_wb;
  logic       Clock = 1'b0;
  logic       Resetn = 1'b0;
  logic       Req = 1'b0;
  logic       Write = 1'b0;
  logic [6:0] Address = '0;
  logic [4:0] BlockIn = '0;
  logic [4:0] BlockOut;
  logic       Done, hit, Busy, C_Req_M, C_Write_M;
  logic [6:0] C_Addr_M;
  logic [4:0] C_Block_M;
  logic [4:0] M_Block_C = '0;
  logic       M_Ack_C = 1'b0;
`ifdef CACHE_FLUSH_EN
  logic       Flush = 1'b0;
`endif

  cache_assoc_wb #(.NUM_LINES(4), .ADDR_W(7), .DATA_W(5)) dut (
    .Clock(Clock), .Resetn(Resetn), .Req(Req), .Write(Write),
    .Address(Address), .BlockIn(BlockIn),
`ifdef CACHE_FLUSH_EN
    .Flush(Flush),
`endif
    .BlockOut(BlockOut), .Done(Done), .hit(hit), .Busy(Busy),
    .C_Req_M(C_Req_M), .C_Write_M(C_Write_M), .C_Addr_M(C_Addr_M),
    .C_Block_M(C_Block_M), .M_Block_C(M_Block_C), .M_Ack_C(M_Ack_C));

  always #5 Clock = ~Clock;

  int errors = 0;
  int checks = 0;

  // Memory model state
  logic [4:0] mem [128];
  int ack_wait = 1;
  int wcnt = 0;
  int wb_cnt = 0;
  int fill_cnt = 0;
  logic [6:0] wb_addr = '0;
  logic [4:0] wb_dat = '0;
  logic [6:0] fill_addr = '0;

  typedef struct {
    bit         rst;
    int         aw;
    bit         w;
    logic [6:0] a;
    logic [4:0] d;
    logic [4:0] out;
    bit         h;
    int         lat;
    int         wbs;
    logic [6:0] wba;
    logic [4:0] wbd;
    int         fills;
  } vec_t;
  vec_t vq[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req_v);
    checks++;
    if (act !== req_v) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, req_v);
    end
  endtask

  task automatic add(input bit rst, input int aw, input bit w, input logic [6:0] a,
                     input logic [4:0] d, input logic [4:0] out, input bit h, input int lat,
                     input int wbs, input logic [6:0] wba, input logic [4:0] wbd, input int fills);
    vec_t v;
    v = '{rst, aw, w, a, d, out, h, lat, wbs, wba, wbd, fills};
    vq.push_back(v);
  endtask

  // Acknowledges a pending request after ack_wait idle request cycles.
  task automatic mem_loop();
    forever begin
      @(negedge Clock);
      if (C_Req_M) begin
        if (wcnt >= ack_wait) begin
          M_Ack_C = 1'b1;
          wcnt = 0;
          if (C_Write_M) begin
            mem[C_Addr_M] = C_Block_M;
            wb_cnt++;
            wb_addr = C_Addr_M;
            wb_dat  = C_Block_M;
          end else begin
            M_Block_C = mem[C_Addr_M];
            fill_cnt++;
            fill_addr = C_Addr_M;
          end
        end else begin
          M_Ack_C = 1'b0;
          wcnt++;
        end
      end else begin
        M_Ack_C = 1'b0;
        wcnt = 0;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge Clock);
    Resetn = 1'b0;
    Req = 1'b0;
    repeat (2) @(negedge Clock);
    Resetn = 1'b1;
  endtask

  task automatic access(input logic w, input logic [6:0] a, input logic [4:0] d,
                        output logic h, output logic [4:0] o, output int lat);
    @(negedge Clock);
    Req = 1'b1; Write = w; Address = a; BlockIn = d;
    @(posedge Clock);
    #1;
    Req = 1'b0;
    lat = 1;
    while (!Done && lat < 60) begin
      @(posedge Clock);
      #1;
      lat++;
    end
    if (!Done) chk("done_timeout", 32'(Done), 32'd1);
    h = hit;
    o = BlockOut;
  endtask

  initial begin
    logic h;
    logic [4:0] o;
    int lat, wb0, fc0, n, dn;

    for (int i = 0; i < 128; i++) begin
      logic [6:0] ai;
      ai = 7'(i);
      mem[i] = ai[4:0] ^ 5'h0A;
    end
    mem[100] = 5'h05;
    fork mem_loop(); join_none

    //   rst aw w  addr d      out    h lat wbs wba  wbd    fills
    add(0, 1, 0, 100, 5'h00, 5'h05, 0, 4, 0, 0,   5'h00, 1);
    add(0, 1, 0, 100, 5'h00, 5'h05, 1, 1, 0, 0,   5'h00, 0);
    add(0, 1, 1, 100, 5'h1F, 5'h1F, 1, 1, 0, 0,   5'h00, 0);
    add(0, 1, 0, 100, 5'h00, 5'h1F, 1, 1, 0, 0,   5'h00, 0);
    add(0, 1, 0, 101, 5'h00, 5'h0F, 0, 4, 0, 0,   5'h00, 1);
    add(0, 1, 0, 102, 5'h00, 5'h0C, 0, 4, 0, 0,   5'h00, 1);
    add(0, 1, 0, 103, 5'h00, 5'h0D, 0, 4, 0, 0,   5'h00, 1);
    add(0, 1, 0, 104, 5'h00, 5'h02, 0, 6, 1, 100, 5'h1F, 1);
    add(1, 1, 0, 100, 5'h00, 5'h1F, 0, 4, 0, 0,   5'h00, 1);
    add(0, 1, 0, 101, 5'h00, 5'h0F, 0, 4, 0, 0,   5'h00, 1);
    add(0, 1, 0, 102, 5'h00, 5'h0C, 0, 4, 0, 0,   5'h00, 1);
    add(0, 1, 0, 103, 5'h00, 5'h0D, 0, 4, 0, 0,   5'h00, 1);
    add(0, 1, 0, 100, 5'h00, 5'h1F, 1, 1, 0, 0,   5'h00, 0);
    add(0, 1, 0, 104, 5'h00, 5'h02, 0, 4, 0, 0,   5'h00, 1);
    add(0, 1, 0, 100, 5'h00, 5'h1F, 1, 1, 0, 0,   5'h00, 0);
    add(0, 1, 0, 103, 5'h00, 5'h0D, 1, 1, 0, 0,   5'h00, 0);
    add(0, 1, 1, 102, 5'h11, 5'h11, 1, 1, 0, 0,   5'h00, 0);
    add(0, 1, 0, 101, 5'h00, 5'h0F, 0, 4, 0, 0,   5'h00, 1);
    add(0, 1, 0, 105, 5'h00, 5'h03, 0, 4, 0, 0,   5'h00, 1);
    add(0, 1, 0, 106, 5'h00, 5'h00, 0, 4, 0, 0,   5'h00, 1);
    add(0, 1, 0, 107, 5'h00, 5'h01, 0, 6, 1, 102, 5'h11, 1);
    add(0, 1, 0, 102, 5'h00, 5'h11, 0, 4, 0, 0,   5'h00, 1);
    add(1, 0, 1, 100, 5'h07, 5'h07, 0, 3, 0, 0,   5'h00, 1);
    add(0, 0, 0, 101, 5'h00, 5'h0F, 0, 3, 0, 0,   5'h00, 1);
    add(0, 0, 0, 102, 5'h00, 5'h11, 0, 3, 0, 0,   5'h00, 1);
    add(0, 0, 0, 103, 5'h00, 5'h0D, 0, 3, 0, 0,   5'h00, 1);
    add(0, 0, 0, 104, 5'h00, 5'h02, 0, 4, 1, 100, 5'h07, 1);
    add(0, 0, 0, 100, 5'h00, 5'h07, 0, 3, 0, 0,   5'h00, 1);

    // Reset state
    #2;
    chk("rst_blockout", 32'(BlockOut), 0);
    chk("rst_done", 32'(Done), 0);
    chk("rst_hit", 32'(hit), 0);
    chk("rst_busy", 32'(Busy), 0);
    chk("rst_creq", 32'(C_Req_M), 0);
    chk("rst_cwrite", 32'(C_Write_M), 0);
    chk("rst_caddr", 32'(C_Addr_M), 0);
    chk("rst_cblock", 32'(C_Block_M), 0);
    do_reset();

    foreach (vq[i]) begin
      ack_wait = vq[i].aw;
      if (vq[i].rst) do_reset();
      wb0 = wb_cnt;
      fc0 = fill_cnt;
      access(vq[i].w, vq[i].a, vq[i].d, h, o, lat);
      chk($sformatf("v%0d_hit", i), 32'(h), 32'(vq[i].h));
      chk($sformatf("v%0d_out", i), 32'(o), 32'(vq[i].out));
      chk($sformatf("v%0d_lat", i), 32'(lat), 32'(vq[i].lat));
      chk($sformatf("v%0d_wbs", i), 32'(wb_cnt - wb0), 32'(vq[i].wbs));
      chk($sformatf("v%0d_fills", i), 32'(fill_cnt - fc0), 32'(vq[i].fills));
      if (vq[i].wbs != 0) begin
        chk($sformatf("v%0d_wb_addr", i), 32'(wb_addr), 32'(vq[i].wba));
        chk($sformatf("v%0d_wb_dat", i), 32'(wb_dat), 32'(vq[i].wbd));
      end
      if (vq[i].fills != 0) chk($sformatf("v%0d_fill_addr", i), 32'(fill_addr), 32'(vq[i].a));
    end

    // Req held during a miss is ignored while Busy; outputs hold after Done.
    ack_wait = 2;
    do_reset();
    fc0 = fill_cnt;
    @(negedge Clock);
    Req = 1'b1; Write = 1'b0; Address = 7'd100;
    @(posedge Clock);
    #1;
    Address = 7'd101;
    chk("busy_after_accept", 32'(Busy), 1);
    n = 0;
    while (!Done && n < 40) begin
      @(posedge Clock);
      #1;
      n++;
    end
    Req = 1'b0;
    chk("busy_done", 32'(Done), 1);
    chk("busy_out", 32'(BlockOut), 32'h07);
    chk("busy_hit", 32'(hit), 0);
    chk("busy_fills", 32'(fill_cnt - fc0), 1);
    chk("busy_fill_addr", 32'(fill_addr), 100);
    @(posedge Clock);
    #1;
    chk("hold_done", 32'(Done), 0);
    chk("hold_out", 32'(BlockOut), 32'h07);
    repeat (4) @(posedge Clock);
    #1;
    chk("ignored_req_fills", 32'(fill_cnt - fc0), 1);
    chk("ignored_req_busy", 32'(Busy), 0);

    // Back-to-back hits at one per cycle
    access(1'b0, 7'd102, 5'h00, h, o, lat);
    chk("b2b_pre_out", 32'(o), 32'h11);
    @(negedge Clock);
    Req = 1'b1; Write = 1'b0; Address = 7'd100;
    @(posedge Clock);
    #1;
    chk("b2b_1_done", 32'(Done), 1);
    chk("b2b_1_hit", 32'(hit), 1);
    chk("b2b_1_out", 32'(BlockOut), 32'h07);
    Address = 7'd102;
    @(posedge Clock);
    #1;
    Req = 1'b0;
    chk("b2b_2_done", 32'(Done), 1);
    chk("b2b_2_hit", 32'(hit), 1);
    chk("b2b_2_out", 32'(BlockOut), 32'h11);

    // Reset mid-fill
    @(negedge Clock);
    Req = 1'b1; Write = 1'b0; Address = 7'd101;
    @(posedge Clock);
    #1;
    Req = 1'b0;
    chk("midfill_creq", 32'(C_Req_M), 1);
    chk("midfill_caddr", 32'(C_Addr_M), 101);
    chk("midfill_cwrite", 32'(C_Write_M), 0);
    #2;
    Resetn = 1'b0;
    #1;
    chk("midfill_rst_creq", 32'(C_Req_M), 0);
    chk("midfill_rst_busy", 32'(Busy), 0);
    @(negedge Clock);
    Resetn = 1'b1;
    access(1'b0, 7'd100, 5'h00, h, o, lat);
    chk("after_rst_100_hit", 32'(h), 0);
    chk("after_rst_100_out", 32'(o), 32'h07);
    access(1'b0, 7'd101, 5'h00, h, o, lat);
    chk("after_rst_101_hit", 32'(h), 0);
    chk("after_rst_101_out", 32'(o), 32'h0F);

`ifdef CACHE_FLUSH_EN
    ack_wait = 1;
    do_reset();
    access(1'b1, 7'd110, 5'h15, h, o, lat);
    access(1'b1, 7'd111, 5'h16, h, o, lat);
    access(1'b0, 7'd112, 5'h00, h, o, lat);
    wb0 = wb_cnt;
    fc0 = fill_cnt;
    @(negedge Clock);
    Flush = 1'b1; Req = 1'b1; Write = 1'b0; Address = 7'd113;
    @(posedge Clock);
    #1;
    Flush = 1'b0; Req = 1'b0;
    chk("flush_busy", 32'(Busy), 1);
    dn = 0;
    for (int k = 0; k < 40; k++) begin
      if (Done) begin
        dn++;
        chk("flush_done_hit", 32'(hit), 0);
      end
      @(posedge Clock);
      #1;
    end
    chk("flush_done_count", 32'(dn), 1);
    chk("flush_wbs", 32'(wb_cnt - wb0), 2);
    chk("flush_fills", 32'(fill_cnt - fc0), 0);
    chk("flush_mem110", 32'(mem[110]), 32'h15);
    chk("flush_mem111", 32'(mem[111]), 32'h16);
    access(1'b0, 7'd110, 5'h00, h, o, lat);
    chk("flush_after_110_hit", 32'(h), 0);
    access(1'b0, 7'd112, 5'h00, h, o, lat);
    chk("flush_after_112_hit", 32'(h), 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: actual=running required=finished");
    $fatal(1, "watchdog expired");
  end
endmodule
